// File: rtl/prog_loader.sv
// Streams little-endian bytes into 32-bit words and writes them to instruction memory while holding the CPU.
// Write strobe follows each 4th byte handshake by one cycle; byte_ready drops outside RECV (no byte buffering).
module prog_loader #(
  parameter int DEPTH_WORDS = 64,
  parameter int CNT_W       = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             abort,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             imem_we,
  output logic [31:0]      imem_addr,
  output logic [31:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [31:0]      asm_word;
  logic             we_q;

  logic hs;
  logic num_ok;
  logic last_word;

  assign hs        = byte_valid & byte_ready;
  assign num_ok    = (num_words != '0) && (32'(num_words) <= 32'(DEPTH_WORDS));
  assign last_word = ((word_idx + CNT_W'(1)) == word_cnt);

  // abort must suppress the strobe in the very cycle it arrives
  assign imem_we = we_q & ~abort;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      word_cnt   <= '0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      asm_word   <= '0;
      we_q       <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            done <= 1'b0;
            if (num_ok) begin
              state      <= RECV;
              word_cnt   <= num_words;
              word_idx   <= '0;
              byte_cnt   <= '0;
              asm_word   <= '0;
              err        <= 1'b0;
              byte_ready <= 1'b1;
              busy       <= 1'b1;
              cpu_hold   <= 1'b1;
            end else begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
        end

        RECV: begin
          if (abort) begin
            state      <= IDLE;
            err        <= 1'b1;
            byte_ready <= 1'b0;
            busy       <= 1'b0;
            we_q       <= 1'b0;
            byte_cnt   <= '0;
            asm_word   <= '0;
          end else if (hs) begin
            asm_word[8*byte_cnt +: 8] <= byte_data;
            byte_cnt                  <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state      <= WRITE;
              byte_ready <= 1'b0;
              we_q       <= 1'b1;
              imem_addr  <= 32'(word_idx) << 2;
              imem_wdata <= {byte_data, asm_word[23:0]};
            end
          end
        end

        WRITE: begin
          we_q <= 1'b0;
          if (abort) begin
            state    <= IDLE;
            err      <= 1'b1;
            busy     <= 1'b0;
            byte_cnt <= '0;
            asm_word <= '0;
          end else if (last_word) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            state      <= RECV;
            word_idx   <= word_idx + CNT_W'(1);
            byte_cnt   <= '0;
            asm_word   <= '0;
            byte_ready <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: byte streaming, write addressing, error/abort/reset handling.
module tb_prog_loader;
  localparam int DEPTH = 64;
  localparam int CW    = 7;

  logic          clk, reset, start, abort, byte_valid;
  logic [CW-1:0] num_words;
  logic [7:0]    byte_data;
  logic          byte_ready, imem_we, cpu_hold, busy, done, err;
  logic [31:0]   imem_addr, imem_wdata;

  int n_cmp = 0;
  int n_bad = 0;
  int load_bytes = 0;
  int wbase = 0;
  int we_total = 0;
  int ref_cnt;
  logic [31:0] exp_w[$];
  logic [31:0] wlog_a[$];
  logic [31:0] wlog_d[$];

  prog_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // every write must land after its 4th byte, at the right address, with the expected word
  always @(negedge clk) begin
    if (reset && imem_we) begin
      check("we_after_4th_byte", 32'(load_bytes), 32'(4 * (we_total - wbase + 1)));
      check("we_addr", imem_addr, 32'((we_total - wbase) * 4));
      if (we_total - wbase < exp_w.size())
        check("we_data", imem_wdata, exp_w[we_total - wbase]);
      else
        check("we_unexpected", 32'(we_total - wbase), 32'(exp_w.size() - 1));
      wlog_a.push_back(imem_addr);
      wlog_d.push_back(imem_wdata);
      we_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    check("rst_ready", 32'(byte_ready), 0);
    check("rst_we", 32'(imem_we), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_wdata", imem_wdata, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_hold", 32'(cpu_hold), 1);
  endtask

  task automatic do_start(input int n);
    load_bytes = 0;
    wbase      = we_total;
    start      = 1'b1;
    num_words  = CW'(n);
    tick();
    start      = 1'b0;
    num_words  = '0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) begin
      byte_valid = 1'b0;
      byte_data  = 8'h5A;
      tick();
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = byte_ready;
      @(posedge clk);
      #1;
    end
    if (ok) load_bytes++;
    else check("hs_timeout", 32'(byte_ready), 1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], rnd ? int'($urandom_range(0, 2)) : 0);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(done), 1);
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_words = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    #12;
    check_rst();
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    check("idle_ready", 32'(byte_ready), 0);
    check("idle_hold", 32'(cpu_hold), 1);

    // two words back-to-back
    exp_w = '{32'h12345678, 32'hDEADBEEF};
    do_start(2);
    check("t1_busy", 32'(busy), 1);
    check("t1_ready", 32'(byte_ready), 1);
    check("t1_hold", 32'(cpu_hold), 1);
    send_word(32'h12345678, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    wait_done();
    check("t1_wr_cnt", 32'(we_total - wbase), 2);
    check("t1_a0", wlog_a[wbase], 32'h0);
    check("t1_d0", wlog_d[wbase], 32'h12345678);
    check("t1_a1", wlog_a[wbase+1], 32'h4);
    check("t1_d1", wlog_d[wbase+1], 32'hDEADBEEF);
    check("t1_hold_done", 32'(cpu_hold), 0);
    check("t1_busy_done", 32'(busy), 0);
    check("t1_err", 32'(err), 0);

    // three words with irregular byte_valid gaps
    exp_w = '{32'h11223344, 32'hA5A55A5A, 32'h0BADF00D};
    do_start(3);
    send_word(32'h11223344, 1'b1);
    send_word(32'hA5A55A5A, 1'b1);
    send_word(32'h0BADF00D, 1'b1);
    wait_done();
    repeat (3) tick();
    check("t2_wr_cnt", 32'(we_total - wbase), 3);
    check("t2_a2", wlog_a[wbase+2], 32'h8);
    check("t2_d1", wlog_d[wbase+1], 32'hA5A55A5A);

    // out-of-range counts are rejected
    ref_cnt = we_total;
    do_start(0);
    check("t3_err0", 32'(err), 1);
    check("t3_done0", 32'(done), 0);
    check("t3_ready0", 32'(byte_ready), 0);
    check("t3_busy0", 32'(busy), 0);
    check("t3_hold0", 32'(cpu_hold), 0);
    do_start(DEPTH + 1);
    check("t3_err65", 32'(err), 1);
    check("t3_ready65", 32'(byte_ready), 0);
    byte_valid = 1'b1;
    repeat (3) tick();
    byte_valid = 1'b0;
    check("t3_no_wr", 32'(we_total), 32'(ref_cnt));

    // abort after 2 bytes of the second word, then a clean 1-word reload
    exp_w = '{32'h01020304};
    do_start(2);
    send_word(32'h01020304, 1'b0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_err", 32'(err), 1);
    check("t4_busy", 32'(busy), 0);
    check("t4_done", 32'(done), 0);
    check("t4_hold", 32'(cpu_hold), 1);
    check("t4_ready", 32'(byte_ready), 0);
    byte_valid = 1'b1;
    repeat (5) tick();
    byte_valid = 1'b0;
    check("t4_wr_cnt", 32'(we_total - wbase), 1);
    exp_w = '{32'hCAFEF00D};
    do_start(1);
    check("t4_err_clr", 32'(err), 0);
    send_word(32'hCAFEF00D, 1'b0);
    wait_done();
    check("t4_re_a0", wlog_a[wbase], 32'h0);
    check("t4_re_d0", wlog_d[wbase], 32'hCAFEF00D);

    // abort coinciding with the write cycle suppresses the strobe
    exp_w = '{32'h55667788};
    do_start(1);
    send_byte(8'h88, 0);
    send_byte(8'h77, 0);
    send_byte(8'h66, 0);
    send_byte(8'h55, 0);
    abort = 1'b1;
    @(negedge clk);
    check("t5_we", 32'(imem_we), 0);
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (2) tick();
    check("t5_err", 32'(err), 1);
    check("t5_done", 32'(done), 0);
    check("t5_hold", 32'(cpu_hold), 1);
    check("t5_wr_cnt", 32'(we_total - wbase), 0);

    // full-depth load
    exp_w.delete();
    for (int i = 0; i < DEPTH; i++) exp_w.push_back(32'(i) * 32'h01000193 + 32'h7);
    do_start(DEPTH);
    for (int i = 0; i < DEPTH; i++) send_word(exp_w[i], 1'b0);
    wait_done();
    check("t6_wr_cnt", 32'(we_total - wbase), 32'(DEPTH));
    check("t6_last_a", wlog_a[we_total-1], 32'((DEPTH - 1) * 4));
    check("t6_last_d", wlog_d[we_total-1], 32'(63) * 32'h01000193 + 32'h7);

    // reset mid-load, then a start while busy is ignored
    exp_w = '{32'h89ABCDEF};
    do_start(3);
    send_word(32'h89ABCDEF, 1'b0);
    send_byte(8'h42, 0);
    #2;
    reset = 1'b0;
    #1;
    check_rst();
    #2;
    reset = 1'b1;
    tick();
    ref_cnt = we_total;
    byte_valid = 1'b1;
    repeat (3) tick();
    byte_valid = 1'b0;
    check("t7_idle_ready", 32'(byte_ready), 0);
    check("t7_no_wr", 32'(we_total), 32'(ref_cnt));
    exp_w = '{32'h10203040, 32'h50607080};
    do_start(2);
    send_word(32'h10203040, 1'b0);
    start = 1'b1;
    num_words = CW'(1);
    tick();
    start = 1'b0;
    num_words = '0;
    check("t7_busy_start_done", 32'(done), 0);
    check("t7_busy_start_busy", 32'(busy), 1);
    send_word(32'h50607080, 1'b0);
    wait_done();
    check("t7_wr_cnt", 32'(we_total - wbase), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
